// File: rtl/voice_allocator_pkg.sv
// Shared constants for the voice allocator: FSM encoding, MIDI field widths
// and the velocity-to-amplitude mapping used by every voice slot.
package voice_allocator_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SCAN  = 2'd1;
   localparam logic [1:0] ST_ISSUE = 2'd2;
   localparam logic [1:0] ST_PANIC = 2'd3;

   localparam int GATE_BIT     = 7;
   localparam int MIDI_NOTE_W  = 7;
   localparam int MIDI_VEL_W   = 7;
   localparam int VOICE_DATA_W = 8;

   function automatic logic [VOICE_DATA_W-1:0] vel_to_amp(input logic [MIDI_VEL_W-1:0] vel);
      return {vel, 1'b0};
   endfunction

endpackage

// File: rtl/voice_allocator_if.sv
// Note-event handshake between the MIDI parser (master) and the allocator (slave).
interface voice_allocator_if;
   import voice_allocator_pkg::*;

   logic                   ev_valid;
   logic                   ev_ready;
   logic                   ev_note_on;
   logic [MIDI_NOTE_W-1:0] ev_note;
   logic [MIDI_VEL_W-1:0]  ev_velocity;

   modport master (output ev_valid, output ev_note_on, output ev_note,
                   output ev_velocity, input ev_ready);
   modport slave  (input ev_valid, input ev_note_on, input ev_note,
                   input ev_velocity, output ev_ready);
endinterface

// File: rtl/voice_slot.sv
// State of one polyphony slot: gate, note, held amplitude and a saturating
// age counter. set wins over clr, which wins over age_inc.
module voice_slot
   import voice_allocator_pkg::*;
#(
   parameter int AGE_W = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_set,
   input  logic                    i_clr,
   input  logic                    i_age_inc,
   input  logic [MIDI_NOTE_W-1:0]  i_note,
   input  logic [VOICE_DATA_W-1:0] i_amp,
   output logic                    o_gate,
   output logic [MIDI_NOTE_W-1:0]  o_note,
   output logic [VOICE_DATA_W-1:0] o_amp,
   output logic [AGE_W-1:0]        o_age
);

   logic                    r_gate;
   logic [MIDI_NOTE_W-1:0]  r_note;
   logic [VOICE_DATA_W-1:0] r_amp;
   logic [AGE_W-1:0]        r_age;

   // Slot registers; note and amplitude survive gate-off so the release tail plays
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_gate <= 1'b0;
         r_note <= '0;
         r_amp  <= '0;
         r_age  <= '0;
      end else if (i_set) begin
         r_gate <= 1'b1;
         r_note <= i_note;
         r_amp  <= i_amp;
         r_age  <= '0;
      end else if (i_clr) begin
         r_gate <= 1'b0;
      end else if (i_age_inc && (r_age != {AGE_W{1'b1}})) begin
         r_age <= r_age + AGE_W'(1);
      end
   end

   assign o_gate = r_gate;
   assign o_note = r_note;
   assign o_amp  = r_amp;
   assign o_age  = r_age;

endmodule

// File: rtl/voice_allocator.sv
// Polyphony allocator: scans the slot bank one slot per cycle, then retriggers,
// fills a free slot or steals the oldest, and strobes the updated voice.
module voice_allocator
   import voice_allocator_pkg::*;
#(
   parameter int NUM_VOICES = 4,
   parameter int AGE_W      = 8
) (
   input  logic                               clk,
   input  logic                               rst_n,
   voice_allocator_if.slave                   ev_if,
   input  logic                               panic,
   output logic [VOICE_DATA_W*NUM_VOICES-1:0] voice_midi_data,
   output logic [NUM_VOICES-1:0]              voice_valid,
   output logic [VOICE_DATA_W*NUM_VOICES-1:0] voice_amplitude,
   output logic [NUM_VOICES-1:0]              voices_active
);

   localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

   logic [1:0]             r_state;
   logic [IDX_W-1:0]       r_idx;
   logic                   r_panic_pend;
   logic                   r_note_on;
   logic [MIDI_NOTE_W-1:0] r_note;
   logic [MIDI_VEL_W-1:0]  r_vel;
   logic                   r_match_found;
   logic [IDX_W-1:0]       r_match_idx;
   logic                   r_free_found;
   logic [IDX_W-1:0]       r_free_idx;
   logic [IDX_W-1:0]       r_old_idx;
   logic [AGE_W-1:0]       r_old_age;
   logic [NUM_VOICES-1:0]  r_valid;

   logic [NUM_VOICES-1:0]   w_gate;
   logic [MIDI_NOTE_W-1:0]  w_note [NUM_VOICES];
   logic [VOICE_DATA_W-1:0] w_amp  [NUM_VOICES];
   logic [AGE_W-1:0]        w_age  [NUM_VOICES];
   logic [NUM_VOICES-1:0]   w_set;
   logic [NUM_VOICES-1:0]   w_clr;
   logic [NUM_VOICES-1:0]   w_age_inc;
   logic                    w_panic_req;
   logic                    w_accept;
   logic                    w_is_on;
   logic [IDX_W-1:0]        w_target;
   logic                    w_cur_gate;
   logic [MIDI_NOTE_W-1:0]  w_cur_note;
   logic [AGE_W-1:0]        w_cur_age;

   // A panic arriving this very cycle already blocks acceptance
   assign w_panic_req    = r_panic_pend | panic;
   assign ev_if.ev_ready = (r_state == ST_IDLE) & ~w_panic_req;
   assign w_accept       = ev_if.ev_valid & ev_if.ev_ready;
   assign w_is_on        = r_note_on & (r_vel != '0);
   assign w_target       = r_match_found ? r_match_idx :
                           (r_free_found ? r_free_idx : r_old_idx);

   assign w_cur_gate = w_gate[r_idx];
   assign w_cur_note = w_note[r_idx];
   assign w_cur_age  = w_age[r_idx];

   // Panic latch: set on any cycle, consumed when IDLE enters PANIC
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_panic_pend <= 1'b0;
      end else if ((r_state == ST_IDLE) && w_panic_req) begin
         r_panic_pend <= 1'b0;
      end else if (panic) begin
         r_panic_pend <= 1'b1;
      end
   end

   // Main FSM: event latch, per-slot scan bookkeeping and panic walk index
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_idx         <= '0;
         r_note_on     <= 1'b0;
         r_note        <= '0;
         r_vel         <= '0;
         r_match_found <= 1'b0;
         r_match_idx   <= '0;
         r_free_found  <= 1'b0;
         r_free_idx    <= '0;
         r_old_idx     <= '0;
         r_old_age     <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_panic_req) begin
                  r_state <= ST_PANIC;
                  r_idx   <= '0;
               end else if (w_accept) begin
                  r_state       <= ST_SCAN;
                  r_idx         <= '0;
                  r_note_on     <= ev_if.ev_note_on;
                  r_note        <= ev_if.ev_note;
                  r_vel         <= ev_if.ev_velocity;
                  r_match_found <= 1'b0;
                  r_free_found  <= 1'b0;
               end
            end
            ST_SCAN: begin
               if (!r_match_found && w_cur_gate && (w_cur_note == r_note)) begin
                  r_match_found <= 1'b1;
                  r_match_idx   <= r_idx;
               end
               if (!r_free_found && !w_cur_gate) begin
                  r_free_found <= 1'b1;
                  r_free_idx   <= r_idx;
               end
               // Strict compare keeps the lowest index on equal ages
               if ((r_idx == '0) || (w_cur_age > r_old_age)) begin
                  r_old_idx <= r_idx;
                  r_old_age <= w_cur_age;
               end
               if (r_idx == LAST_IDX) begin
                  r_state <= ST_ISSUE;
               end else begin
                  r_idx <= r_idx + IDX_W'(1);
               end
            end
            ST_ISSUE: begin
               r_state <= ST_IDLE;
            end
            ST_PANIC: begin
               if (r_idx == LAST_IDX) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_idx <= r_idx + IDX_W'(1);
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Slot update controls for the ISSUE decision and the panic walk
   always_comb begin
      w_set     = '0;
      w_clr     = '0;
      w_age_inc = '0;
      case (r_state)
         ST_ISSUE: begin
            if (w_is_on) begin
               w_set[w_target] = 1'b1;
               w_age_inc       = w_gate & ~w_set;
            end else if (r_match_found) begin
               w_clr[r_match_idx] = 1'b1;
            end else begin
               w_clr = '0;
            end
         end
         ST_PANIC: begin
            w_clr[r_idx] = w_gate[r_idx];
         end
         default: begin
            w_clr = '0;
         end
      endcase
   end

   // One-cycle strobe aligned with the slot register update
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
      end else begin
         r_valid <= w_set | w_clr;
      end
   end

   assign voice_valid   = r_valid;
   assign voices_active = w_gate;

   for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_slot
      voice_slot #(.AGE_W(AGE_W)) u_slot (
         .clk       (clk),
         .rst_n     (rst_n),
         .i_set     (w_set[gi]),
         .i_clr     (w_clr[gi]),
         .i_age_inc (w_age_inc[gi]),
         .i_note    (r_note),
         .i_amp     (vel_to_amp(r_vel)),
         .o_gate    (w_gate[gi]),
         .o_note    (w_note[gi]),
         .o_amp     (w_amp[gi]),
         .o_age     (w_age[gi])
      );
      assign voice_midi_data[gi*VOICE_DATA_W + GATE_BIT]       = w_gate[gi];
      assign voice_midi_data[gi*VOICE_DATA_W +: MIDI_NOTE_W]   = w_note[gi];
      assign voice_amplitude[gi*VOICE_DATA_W +: VOICE_DATA_W]  = w_amp[gi];
   end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: a slot-level allocation model checked
// every cycle, plus literal expectations from hand-worked scenarios.
module tb_voice_allocator;

   localparam int NV = 4;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           panic = 1'b0;
   logic [8*NV-1:0] voice_midi_data;
   logic [NV-1:0]   voice_valid;
   logic [8*NV-1:0] voice_amplitude;
   logic [NV-1:0]   voices_active;

   voice_allocator_if ev_if ();

   voice_allocator #(.NUM_VOICES(NV), .AGE_W(8)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .ev_if           (ev_if),
      .panic           (panic),
      .voice_midi_data (voice_midi_data),
      .voice_valid     (voice_valid),
      .voice_amplitude (voice_amplitude),
      .voices_active   (voices_active)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Allocation model: one entry per slot
   bit         m_gate [NV];
   logic [6:0] m_note [NV];
   logic [7:0] m_amp  [NV];
   int         m_age  [NV];

   logic [NV-1:0] exp_valid = '0;
   logic          exp_ready = 1'b1;
   bit            chk_en = 1'b0;

   int acc_cyc = 0;
   int rise_cyc = 0;
   logic rdy_q = 1'b0;
   int strobe_cnt = 0;
   logic [NV-1:0] last_strobe = '0;
   int strobe_cyc = 0;
   bit in_panic = 1'b0;
   int ps [8];
   int ps_cnt = 0;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   function automatic logic [8*NV-1:0] pack_data();
      logic [8*NV-1:0] v;
      for (int i = 0; i < NV; i++) v[i*8 +: 8] = {m_gate[i], m_note[i]};
      return v;
   endfunction

   function automatic logic [8*NV-1:0] pack_amp();
      logic [8*NV-1:0] v;
      for (int i = 0; i < NV; i++) v[i*8 +: 8] = m_amp[i];
      return v;
   endfunction

   function automatic logic [NV-1:0] pack_gate();
      logic [NV-1:0] v;
      for (int i = 0; i < NV; i++) v[i] = m_gate[i];
      return v;
   endfunction

   function automatic int onehot_idx(input logic [NV-1:0] v);
      int r;
      r = -1;
      for (int i = 0; i < NV; i++) if (v[i] && r < 0) r = i;
      return r;
   endfunction

   // Rules: retrigger matching active note, else lowest free, else oldest (lowest on tie)
   task automatic model_event(input logic on, input logic [6:0] note, input logic [6:0] vel,
                              output int slot);
      int match;
      int t;
      match = -1;
      slot = -1;
      for (int i = 0; i < NV; i++)
         if (m_gate[i] && m_note[i] == note && match < 0) match = i;
      if (on && vel != 7'd0) begin
         t = match;
         if (t < 0)
            for (int i = 0; i < NV; i++) if (!m_gate[i] && t < 0) t = i;
         if (t < 0) begin
            t = 0;
            for (int i = 1; i < NV; i++) if (m_age[i] > m_age[t]) t = i;
         end
         for (int i = 0; i < NV; i++)
            if (i != t && m_gate[i] && m_age[i] < 255) m_age[i] = m_age[i] + 1;
         m_gate[t] = 1'b1;
         m_note[t] = note;
         m_amp[t]  = {vel, 1'b0};
         m_age[t]  = 0;
         slot = t;
      end else if (match >= 0) begin
         m_gate[match] = 1'b0;
         slot = match;
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en) begin
         cmp("voice_valid", 32'(voice_valid), 32'(exp_valid));
         cmp("voices_active", 32'(voices_active), 32'(pack_gate()));
         cmp("voice_midi_data", 32'(voice_midi_data), 32'(pack_data()));
         cmp("voice_amplitude", 32'(voice_amplitude), 32'(pack_amp()));
         cmp("ev_ready", 32'(ev_if.ev_ready), 32'(exp_ready));
         cmp("valid_onehot", 32'($countones(voice_valid) <= 1), 32'd1);
      end
   end

   always @(negedge clk) begin
      rdy_q <= ev_if.ev_ready;
      if (ev_if.ev_ready && !rdy_q) rise_cyc <= cyc;
      if (voice_valid != '0) begin
         strobe_cnt  <= strobe_cnt + 1;
         last_strobe <= voice_valid;
         strobe_cyc  <= cyc;
         if (in_panic && ev_if.ev_valid && ps_cnt < 8) begin
            ps[ps_cnt] <= onehot_idx(voice_valid);
            ps_cnt     <= ps_cnt + 1;
         end
      end
   end

   // Called one step after the accepting edge
   task automatic finish_event(input logic on, input logic [6:0] note, input logic [6:0] vel);
      int slot;
      acc_cyc = cyc;
      ev_if.ev_valid = 1'b0;
      exp_valid = '0;
      exp_ready = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      model_event(on, note, vel, slot);
      if (slot >= 0) exp_valid[slot] = 1'b1;
      exp_ready = 1'b1;
      @(posedge clk);
      #1;
      exp_valid = '0;
   endtask

   task automatic send_event(input logic on, input logic [6:0] note, input logic [6:0] vel);
      bit ok;
      ev_if.ev_note_on  = on;
      ev_if.ev_note     = note;
      ev_if.ev_velocity = vel;
      ev_if.ev_valid    = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 50 && !ok; k++) begin
         if (ev_if.ev_ready) ok = 1'b1;
         @(posedge clk);
         #1;
      end
      cmp("accept", 32'(ok), 32'd1);
      if (ok) finish_event(on, note, vel);
      else ev_if.ev_valid = 1'b0;
   endtask

   task automatic do_panic_with_held_event();
      ev_if.ev_note_on  = 1'b1;
      ev_if.ev_note     = 7'd72;
      ev_if.ev_velocity = 7'd10;
      ev_if.ev_valid    = 1'b1;
      panic     = 1'b1;
      exp_ready = 1'b0;
      in_panic  = 1'b1;
      @(posedge clk);
      #1;
      panic = 1'b0;
      for (int k = 0; k < NV; k++) begin
         @(posedge clk);
         #1;
         exp_valid = '0;
         if (m_gate[k]) begin
            m_gate[k]    = 1'b0;
            exp_valid[k] = 1'b1;
         end
      end
      exp_ready = 1'b1;
      send_event(1'b1, 7'd72, 7'd10);
      in_panic = 1'b0;
   endtask

   int sc0;

   initial begin
      for (int i = 0; i < NV; i++) begin
         m_gate[i] = 1'b0; m_note[i] = '0; m_amp[i] = '0; m_age[i] = 0;
      end
      ev_if.ev_valid = 1'b0; ev_if.ev_note_on = 1'b0;
      ev_if.ev_note = '0; ev_if.ev_velocity = '0;
      repeat (3) @(posedge clk);
      #1;
      cmp("reset_data", voice_midi_data, 32'h0);
      cmp("reset_valid", 32'(voice_valid), 32'h0);
      rst_n = 1'b1;
      chk_en = 1'b1;
      @(posedge clk);
      #1;

      // 1: first note-on lands in slot 0
      send_event(1'b1, 7'd60, 7'd100);
      cmp("t1_strobe", 32'(last_strobe), 32'h1);
      cmp("t1_latency", 32'(strobe_cyc - acc_cyc), 32'd5);
      cmp("t1_data", 32'(voice_midi_data[7:0]), 32'hBC);
      cmp("t1_amp", 32'(voice_amplitude[7:0]), 32'd200);
      cmp("t1_active", 32'(voices_active), 32'h1);

      // 2: fill the bank, then steal the oldest
      send_event(1'b1, 7'd62, 7'd80);
      send_event(1'b1, 7'd64, 7'd70);
      send_event(1'b1, 7'd67, 7'd60);
      send_event(1'b1, 7'd69, 7'd50);
      cmp("t2_steal", voice_midi_data, 32'hC3C0BEC5);
      cmp("t2_amp0", 32'(voice_amplitude[7:0]), 32'd100);

      // 3: retrigger active note 62
      sc0 = strobe_cnt;
      send_event(1'b1, 7'd62, 7'd90);
      cmp("t3_strobe", 32'(last_strobe), 32'h2);
      cmp("t3_count", 32'(strobe_cnt - sc0), 32'd1);
      cmp("t3_amp1", 32'(voice_amplitude[15:8]), 32'd180);

      // 4: release 64, then 71 reuses the freed slot
      send_event(1'b0, 7'd64, 7'd0);
      cmp("t4_off", 32'(voice_midi_data[23:16]), 32'h40);
      cmp("t4_active", 32'(voices_active), 32'hB);
      send_event(1'b1, 7'd71, 7'd50);
      cmp("t4_reuse", 32'(voice_midi_data[23:16]), 32'hC7);
      cmp("t4_strobe", 32'(last_strobe), 32'h4);

      // 5: unmatched note-off
      sc0 = strobe_cnt;
      send_event(1'b0, 7'd50, 7'd0);
      cmp("t5_nostrobe", 32'(strobe_cnt - sc0), 32'd0);
      cmp("t5_ready_lat", 32'(rise_cyc - acc_cyc), 32'd5);

      // Steal must pick slot 3: slot 1's age was cleared by the retrigger
      send_event(1'b1, 7'd40, 7'd30);
      cmp("steal_aged", 32'(voice_midi_data[31:24]), 32'hA8);
      send_event(1'b1, 7'd62, 7'd0);
      send_event(1'b0, 7'd40, 7'd0);
      cmp("vel0_off", 32'(voices_active), 32'h5);

      // 6: panic with slots 0 and 2 active, event held meanwhile
      do_panic_with_held_event();
      cmp("t6_pcount", 32'(ps_cnt), 32'd2);
      cmp("t6_first", 32'(ps[0]), 32'd0);
      cmp("t6_second", 32'(ps[1]), 32'd2);
      cmp("t6_after", 32'(voice_midi_data[7:0]), 32'hC8);
      cmp("t6_active", 32'(voices_active), 32'h1);

      repeat (2) @(posedge clk);
      #1;
      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, %0d errors so far", errors);
      $fatal(1, "watchdog");
   end

endmodule
